// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and constants for the EX-stage multiply/divide unit.
package mips_muldiv_pkg;

  // Operation encoding as delivered by ID/EX.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  // Quotient reported on divide by zero; wide enough for any supported WIDTH.
  localparam int unsigned DIVZERO_W = 64;
  localparam logic [DIVZERO_W-1:0] DIVZERO_LO = '1;

  // Signed ops have a zero in bit 0 of the encoding.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Divide ops have a one in bit 1 of the encoding.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative shift-add multiply / restoring divide datapath, one step per enabled edge.
module muldiv_iter
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   lo_i,
  input  logic [WIDTH-1:0]   op_b_i,
  output logic [2*WIDTH-1:0] acc_o
);

  // acc_q = {upper half, lower half}:
  //   multiply: {partial product, remaining multiplier bits}
  //   divide:   {remainder, dividend bits shifting into quotient}
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   b_q;
  logic               div_q;

  logic [WIDTH:0]     mul_sum_c;
  logic [2*WIDTH-1:0] mul_next_c;
  logic [WIDTH:0]     rem_sh_c;
  logic [WIDTH-1:0]   rem_sub_c;
  logic               rem_ge_c;
  logic [2*WIDTH-1:0] div_next_c;

  // One multiply step and one divide step, computed in parallel.
  always_comb begin
    mul_sum_c  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    mul_next_c = {mul_sum_c, acc_q[WIDTH-1:1]};

    // Remainder stays below the divisor, so the difference fits in WIDTH bits.
    rem_sh_c   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_ge_c   = rem_sh_c >= {1'b0, b_q};
    rem_sub_c  = rem_sh_c[WIDTH-1:0] - b_q;
    div_next_c = rem_ge_c ? {rem_sub_c, acc_q[WIDTH-2:0], 1'b1}
                          : {rem_sh_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  // Operand load on start, then one iteration per enabled edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      acc_q <= {{WIDTH{1'b0}}, lo_i};
      b_q   <= op_b_i;
      div_q <= is_div_i;
    end else if (step_i) begin
      acc_q <= div_q ? div_next_c : mul_next_c;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
module ex_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               div_q;
  logic               rs_neg_q;
  logic               rt_neg_q;
  logic               divz_q;

  logic               rs_neg_c;
  logic               rt_neg_c;
  logic [WIDTH-1:0]   rs_abs_c;
  logic [WIDTH-1:0]   rt_abs_c;
  logic               load_c;
  logic               step_c;
  logic [2*WIDTH-1:0] acc_c;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   quot_c;
  logic [WIDTH-1:0]   rem_c;
  logic [WIDTH-1:0]   fix_hi_d;
  logic [WIDTH-1:0]   fix_lo_d;

  // Operand magnitudes; unsigned ops pass straight through.
  always_comb begin
    rs_neg_c = op_is_signed(op_i) & rs_data_i[WIDTH-1];
    rt_neg_c = op_is_signed(op_i) & rt_data_i[WIDTH-1];
    rs_abs_c = rs_neg_c ? -rs_data_i : rs_data_i;
    rt_abs_c = rt_neg_c ? -rt_data_i : rt_data_i;
    load_c   = (state_q == IDLE) & start_i & ~flush_i;
    step_c   = (state_q == RUN) & ~flush_i;
  end

  // Multiplier (rt) or dividend (rs) goes into the low half of the accumulator.
  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (load_c),
    .step_i   (step_c),
    .is_div_i (op_is_div(op_i)),
    .lo_i     (op_is_div(op_i) ? rs_abs_c : rt_abs_c),
    .op_b_i   (op_is_div(op_i) ? rt_abs_c : rs_abs_c),
    .acc_o    (acc_c)
  );

  // Sign correction of the raw magnitude result for the FIX write.
  always_comb begin
    prod_c = (rs_neg_q ^ rt_neg_q) ? -acc_c : acc_c;
    quot_c = (rs_neg_q ^ rt_neg_q) ? -acc_c[WIDTH-1:0] : acc_c[WIDTH-1:0];
    rem_c  = rs_neg_q ? -acc_c[2*WIDTH-1:WIDTH] : acc_c[2*WIDTH-1:WIDTH];
    if (div_q) begin
      fix_hi_d = rem_c;
      fix_lo_d = divz_q ? WIDTH'(DIVZERO_LO) : quot_c;
    end else begin
      fix_hi_d = prod_c[2*WIDTH-1:WIDTH];
      fix_lo_d = prod_c[WIDTH-1:0];
    end
  end

  // Sequencer, HI/LO ownership and registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div_q    <= 1'b0;
      rs_neg_q <= 1'b0;
      rt_neg_q <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A squash in IDLE also kills any MTHI/MTLO issued alongside it.
          if (!flush_i) begin
            if (hi_we_i) hi_q <= wdata_i;
            if (lo_we_i) lo_q <= wdata_i;
            if (start_i) begin
              div_q    <= op_is_div(op_i);
              rs_neg_q <= rs_neg_c;
              rt_neg_q <= rt_neg_c;
              divz_q   <= (rt_data_i == '0);
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          if (flush_i) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
          end
        end
        FIX: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (!flush_i) begin
            hi_q   <= fix_hi_d;
            lo_q   <= fix_lo_d;
            done_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table plus multi-cycle corner sequences.
module tb_ex_muldiv;
  import mips_muldiv_pkg::*;

  localparam int unsigned W = 32;
  localparam int LAT = 33;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] rs_data_i;
  logic [W-1:0] rt_data_i;
  logic         hi_we_i;
  logic         lo_we_i;
  logic [W-1:0] wdata_i;
  logic         flush_i;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic         busy_o;
  logic         done_o;

  int n_vec = 0;
  int n_err = 0;

  ex_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .rs_data_i (rs_data_i),
    .rt_data_i (rt_data_i),
    .hi_we_i   (hi_we_i),
    .lo_we_i   (lo_we_i),
    .wdata_i   (wdata_i),
    .flush_i   (flush_i),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    md_op_e       op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called right after a negedge; returns right after the negedge following E0.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    start_i   = 1'b1;
    op_i      = op;
    rs_data_i = rs;
    rt_data_i = rt;
    @(negedge clk_i);
    start_i   = 1'b0;
  endtask

  // Counts negedges until busy drops, bounded.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
  endtask

  task automatic write_hilo(input logic hw, input logic lw, input logic [W-1:0] d);
    hi_we_i = hw;
    lo_we_i = lw;
    wdata_i = d;
    @(negedge clk_i);
    hi_we_i = 1'b0;
    lo_we_i = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] rs,
                        input logic [W-1:0] rt, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int cyc;
    issue(op, rs, rt);
    check({tag, "_busy_start"}, W'(busy_o), 32'd1);
    wait_idle(cyc);
    check({tag, "_latency"}, W'(cyc), W'(LAT));
    check({tag, "_done"}, W'(done_o), 32'd1);
    check({tag, "_hi"}, hi_o, ehi);
    check({tag, "_lo"}, lo_o, elo);
    @(negedge clk_i);
    check({tag, "_done_once"}, W'(done_o), 32'd0);
  endtask

  initial begin
    int cyc;
    int dones;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[8]  = '{OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[9]  = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[10] = '{OP_DIVU,  32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF};

    rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; rs_data_i = '0; rt_data_i = '0;
    hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = '0; flush_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    check("reset_hi",   hi_o, 32'd0);
    check("reset_lo",   lo_o, 32'd0);
    check("reset_busy", W'(busy_o), 32'd0);
    check("reset_done", W'(done_o), 32'd0);

    // MTHI / MTLO in IDLE, separately and together.
    write_hilo(1'b1, 1'b0, 32'h1234);
    check("mthi_hi", hi_o, 32'h1234);
    check("mthi_lo", lo_o, 32'd0);
    write_hilo(1'b1, 1'b1, 32'hCAFE0001);
    check("mt_both_hi", hi_o, 32'hCAFE0001);
    check("mt_both_lo", lo_o, 32'hCAFE0001);

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo);
    end

    // MTHI on the start edge lands now, then the result overwrites it.
    start_i = 1'b1; op_i = OP_MULTU; rs_data_i = 32'd2; rt_data_i = 32'd3;
    hi_we_i = 1'b1; wdata_i = 32'h5555;
    @(negedge clk_i);
    start_i = 1'b0; hi_we_i = 1'b0;
    check("mthi_start_hi_now", hi_o, 32'h5555);
    wait_idle(cyc);
    check("mthi_start_latency", W'(cyc), W'(LAT));
    check("mthi_start_hi_final", hi_o, 32'd0);
    check("mthi_start_lo_final", lo_o, 32'd6);
    @(negedge clk_i);

    // MTLO while busy is dropped; a second start while busy is ignored.
    write_hilo(1'b1, 1'b1, 32'h0000ABCD);
    issue(OP_MULTU, 32'd3, 32'd5);
    repeat (3) @(negedge clk_i);
    write_hilo(1'b0, 1'b1, 32'hDEADBEEF);
    check("mtlo_busy_lo", lo_o, 32'h0000ABCD);
    start_i = 1'b1; op_i = OP_DIVU; rs_data_i = 32'd100; rt_data_i = 32'd7;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_idle(cyc);
    check("second_start_latency", W'(cyc), W'(LAT - 5));
    check("second_start_hi", hi_o, 32'd0);
    check("second_start_lo", lo_o, 32'd15);
    @(negedge clk_i);
    check("second_start_idle", W'(busy_o), 32'd0);

    // Flush at cycle 10 of a MULT: abort, keep pre-op HI/LO, no done.
    write_hilo(1'b1, 1'b0, 32'hA5A5A5A5);
    write_hilo(1'b0, 1'b1, 32'h5A5A5A5A);
    issue(OP_MULT, 32'd9, 32'd9);
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_busy", W'(busy_o), 32'd0);
    check("flush_done", W'(done_o), 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      dones += int'(done_o);
      @(negedge clk_i);
    end
    check("flush_no_done", W'(dones), 32'd0);
    check("flush_hi", hi_o, 32'hA5A5A5A5);
    check("flush_lo", lo_o, 32'h5A5A5A5A);

    // Flush with start in IDLE: no op, MTHI suppressed.
    start_i = 1'b1; op_i = OP_DIVU; rs_data_i = 32'd50; rt_data_i = 32'd5;
    flush_i = 1'b1; hi_we_i = 1'b1; wdata_i = 32'h00000BAD;
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0; hi_we_i = 1'b0;
    check("idle_flush_busy", W'(busy_o), 32'd0);
    check("idle_flush_hi", hi_o, 32'hA5A5A5A5);
    repeat (3) @(negedge clk_i);
    check("idle_flush_lo", lo_o, 32'h5A5A5A5A);

    // Asynchronous reset mid-RUN clears everything immediately.
    issue(OP_MULTU, 32'd3, 32'd3);
    repeat (5) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("arst_hi",   hi_o, 32'd0);
    check("arst_lo",   lo_o, 32'd0);
    check("arst_busy", W'(busy_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      dones += int'(done_o) + int'(busy_o);
    end
    check("arst_no_done", W'(dones), 32'd0);
    check("arst_lo_after", lo_o, 32'd0);

    // Unit still works after the abort.
    run_op("post_reset", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
